// File: rtl/adder_multicycle.sv
// WIDTH-bit add (and X-Y when ADDER_SUB_EN is defined) with sign/zero/carry/parity/overflow flags, CHUNK bits per cycle.
// Latency WIDTH/CHUNK cycles from accept to out_valid; throughput one result per WIDTH/CHUNK+1 cycles.
// Backpressure: result and flags hold in DONE while out_ready=0; in_ready stays low until the result is taken.
module adder_multicycle #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] xr, yr, wr, wnext, yp;
    logic             cin, sub_i, accept, msb_cin;
    logic [KW-1:0]    k;
    logic [CHUNK-1:0] xc, yc;
    logic [CHUNK:0]   csum;

`ifdef ADDER_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    // Subtraction is X + ~Y + 1: the +1 enters as the initial carry-in.
    assign yp       = sub_i ? ~Y : Y;
    assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        xc    = xr[int'(k)*CHUNK +: CHUNK];
        yc    = yr[int'(k)*CHUNK +: CHUNK];
        csum  = {1'b0, xc} + {1'b0, yc} + {{CHUNK{1'b0}}, cin};
        // Sum bit = a ^ b ^ carry_in, so the carry into the top bit is recoverable from the chunk sum.
        msb_cin = xc[CHUNK-1] ^ yc[CHUNK-1] ^ csum[CHUNK-1];
        wnext = wr;
        wnext[int'(k)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            xr        <= '0;
            yr        <= '0;
            wr        <= '0;
            cin       <= 1'b0;
            k         <= '0;
            out_valid <= 1'b0;
            Z         <= '0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            parity    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        xr    <= X;
                        yr    <= yp;
                        cin   <= sub_i;
                        k     <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    wr  <= wnext;
                    cin <= csum[CHUNK];
                    if (k == KLAST) begin
                        k         <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Z         <= wnext;
                        sign      <= wnext[WIDTH-1];
                        zero      <= ~|wnext;
                        parity    <= ~^wnext;
                        carry     <= csum[CHUNK];
                        overflow  <= msb_cin ^ csum[CHUNK];
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            xr    <= X;
                            yr    <= yp;
                            cin   <= sub_i;
                            k     <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_multicycle.sv
// Directed bench for adder_multicycle: CHUNK=8 main instance plus CHUNK=1 and CHUNK=32 instances on shared stimulus.
module tb_adder_multicycle;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [31:0] X, Y;
`ifdef ADDER_SUB_EN
    logic        sub;
`endif
    logic [2:0]  rdy, vld, sg, zr, cy, pa, ov;
    logic [31:0] z [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: CHUNK=8, instance 1: CHUNK=1, instance 2: CHUNK=32.
    for (genvar g = 0; g < 3; g++) begin : gd
        adder_multicycle #(.WIDTH(32), .CHUNK(g == 0 ? 8 : (g == 1 ? 1 : 32))) u (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(rdy[g]),
            .X(X), .Y(Y),
`ifdef ADDER_SUB_EN
            .sub(sub),
`endif
            .out_valid(vld[g]), .out_ready(out_ready),
            .Z(z[g]), .sign(sg[g]), .zero(zr[g]), .carry(cy[g]),
            .parity(pa[g]), .overflow(ov[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present operands, accept, then count cycles until out_valid on instance 0.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s, output int lat);
        X = x;
        Y = y;
`ifdef ADDER_SUB_EN
        sub = s;
`else
        if (s) $display("note: subtract vector skipped in add-only build");
`endif
        in_valid = 1'b1;
        #1;
        check("accept_rdy", rdy[0], 1'b1);
        tick;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (vld[0]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] ez,
                           input logic es, input logic ezr, input logic ec,
                           input logic ep, input logic eo);
        check({tag, ".Z"}, z[0], ez);
        check({tag, ".sign"}, sg[0], es);
        check({tag, ".zero"}, zr[0], ezr);
        check({tag, ".carry"}, cy[0], ec);
        check({tag, ".parity"}, pa[0], ep);
        check({tag, ".overflow"}, ov[0], eo);
    endtask

    int          lat;
    int          slat [3];
    logic [31:0] sz [3];
    logic [2:0]  sc;
    logic [32:0] ref_sum;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    int          exp_lat [3];
    logic        seen;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; X = '0; Y = '0;
`ifdef ADDER_SUB_EN
        sub = 1'b0;
`endif
        va = '{32'hA5A5F00F, 32'hFFFFFFFF, 32'h13579BDF};
        vb = '{32'h5A5A1FF1, 32'hFFFFFFFF, 32'hECA86421};
        exp_lat = '{4, 32, 1};

        repeat (2) tick;
        check("rst.out_valid", vld[0], 1'b0);
        check("rst.in_ready", rdy[0], 1'b0);
        chk_res("rst", 32'h0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        check("rst_rel.in_ready", rdy[0], 1'b1);

        run_op(32'h0000FFFF, 32'h00000001, 1'b0, lat);
        check("ffff+1.lat", lat, 4);
        chk_res("ffff+1", 32'h00010000, 0, 0, 0, 0, 0);
        tick;
        check("ffff+1.drop", vld[0], 1'b0);
        check("ffff+1.hold", z[0], 32'h00010000);

        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        check("7fff+1.lat", lat, 4);
        chk_res("7fff+1", 32'h80000000, 1, 0, 0, 0, 1);
        tick;

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
        chk_res("ffffffff+1", 32'h0, 0, 1, 1, 1, 0);
        tick;

`ifdef ADDER_SUB_EN
        run_op(32'd5, 32'd7, 1'b1, lat);
        check("5-7.lat", lat, 4);
        chk_res("5-7", 32'hFFFFFFFE, 1, 0, 0, 0, 0);
        tick;
        run_op(32'h80000000, 32'd1, 1'b1, lat);
        chk_res("min-1", 32'h7FFFFFFF, 0, 0, 1, 0, 1);
        tick;
        sub = 1'b0;
`endif

        // Backpressure: stall 5 cycles in DONE, then consume and accept on the same edge.
        out_ready = 1'b0;
        run_op(32'h12345678, 32'h11111111, 1'b0, lat);
        check("bp.lat", lat, 4);
        check("bp.Z", z[0], 32'h23456789);
        for (int i = 0; i < 5; i++) begin
            X = 32'hDEADBEEF;
            in_valid = 1'b1;
            #1;
            check("bp.in_ready", rdy[0], 1'b0);
            tick;
            check("bp.out_valid", vld[0], 1'b1);
            check("bp.Z_stable", z[0], 32'h23456789);
            check("bp.parity_stable", pa[0], 1'b1);
        end
        X = 32'h00000010;
        Y = 32'h00000020;
        out_ready = 1'b1;
        #1;
        check("bp.release_rdy", rdy[0], 1'b1);
        tick;
        in_valid = 1'b0;
        check("bp.consumed", vld[0], 1'b0);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (vld[0]) begin
                lat = c;
                break;
            end
        end
        check("bp.next_lat", lat, 4);
        chk_res("bp.next", 32'h00000030, 0, 0, 0, 1, 0);
        tick;

        // Reset two cycles after accept.
        X = 32'h1; Y = 32'h2; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        check("mid_rst.out_valid", vld[0], 1'b0);
        chk_res("mid_rst", 32'h0, 0, 0, 0, 0, 0);
        tick;
        rst_n = 1'b1;
        #1;
        check("mid_rst.in_ready", rdy[0], 1'b1);
        seen = 1'b0;
        repeat (10) begin
            tick;
            if (vld[0]) seen = 1'b1;
        end
        check("mid_rst.no_output", seen, 1'b0);

        // CHUNK sweep on shared operands.
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (40) tick;
        for (int v = 0; v < 3; v++) begin
            #1;
            check("sweep.rdy", rdy, 3'b111);
            X = va[v];
            Y = vb[v];
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            slat = '{0, 0, 0};
            sz = '{32'h0, 32'h0, 32'h0};
            sc = '0;
            for (int c = 1; c <= 40; c++) begin
                tick;
                for (int i = 0; i < 3; i++) begin
                    if (vld[i] && slat[i] == 0) begin
                        slat[i] = c;
                        sz[i] = z[i];
                        sc[i] = cy[i];
                    end
                end
            end
            ref_sum = {1'b0, va[v]} + {1'b0, vb[v]};
            for (int i = 0; i < 3; i++) begin
                check($sformatf("sweep%0d.dut%0d.lat", v, i), slat[i], exp_lat[i]);
                check($sformatf("sweep%0d.dut%0d.Z", v, i), sz[i], ref_sum[31:0]);
                check($sformatf("sweep%0d.dut%0d.carry", v, i), sc[i], ref_sum[32]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
